// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the serial ALU subtract path.
package alu_pkg;

  localparam int WIDTH      = 32;
  localparam int SLICE      = 4;
  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = $clog2(NUM_SLICES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_slice4.sv
// Combinational 4-bit subtract slice: a4 + ~b4 + ~borrow_in with full
// generate/propagate lookahead; carry_into_msb feeds signed overflow detection.
module sub_slice4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       borrow_in,
  output logic [3:0] diff4,
  output logic       borrow_out,
  output logic       carry_into_msb
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;
  logic       cin_s;

  // Lookahead carries are each expanded from cin_s so no carry depends on another.
  always_comb begin
    g_s    = a4 & ~b4;
    p_s    = a4 ^ ~b4;
    cin_s  = ~borrow_in;
    c_s[0] = cin_s;
    c_s[1] = g_s[0] | (p_s[0] & cin_s);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin_s);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & cin_s);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin_s);
    diff4          = p_s ^ c_s[3:0];
    borrow_out     = ~c_s[4];
    carry_into_msb = c_s[3];
  end

endmodule

// File: rtl/sub32_serial.sv
// Serial 32-bit subtractor, one 4-bit slice per clock with a registered borrow.
// Define SUB32_SERIAL_COMPARE_EN to add lt_unsigned / lt_signed / eq outputs.
module sub32_serial
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
`ifdef SUB32_SERIAL_COMPARE_EN
  ,
  output logic             lt_unsigned,
  output logic             lt_signed,
  output logic             eq
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  int               slice_idx_s;
  logic [SLICE-1:0] a4_s;
  logic [SLICE-1:0] b4_s;
  logic [SLICE-1:0] diff4_s;
  logic             slice_borrow_s;
  logic             carry_msb_s;
  logic [WIDTH-1:0] next_diff_s;
  logic             ovf_s;

  sub_slice4 u_slice (
    .a4             (a4_s),
    .b4             (b4_s),
    .borrow_in      (borrow_r),
    .diff4          (diff4_s),
    .borrow_out     (slice_borrow_s),
    .carry_into_msb (carry_msb_s)
  );

  // Slice select and merge of the current slice into the running difference.
  always_comb begin
    slice_idx_s = int'(cnt_r) * SLICE;
    a4_s        = a_r[slice_idx_s +: SLICE];
    b4_s        = b_r[slice_idx_s +: SLICE];
    next_diff_s = res_diff;
    next_diff_s[slice_idx_s +: SLICE] = diff4_s;
    // carry out of the MSB is the inverse of the slice borrow
    ovf_s       = carry_msb_s ^ ~slice_borrow_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) next_state_s = RUN;  else next_state_s = IDLE;
      RUN:     if (cnt_r == LAST_CNT) next_state_s = DONE; else next_state_s = RUN;
      DONE:    if (out_ready) next_state_s = IDLE; else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      in_ready  <= (next_state_s == IDLE);
      out_valid <= (next_state_s == DONE);
    end
  end

  // Operand capture, slice iteration and final flag generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      borrow_r    <= 1'b0;
      res_diff    <= {WIDTH{1'b0}};
      borrow_out  <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
`ifdef SUB32_SERIAL_COMPARE_EN
      lt_unsigned <= 1'b0;
      lt_signed   <= 1'b0;
      eq          <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= borrow_in;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          res_diff <= next_diff_s;
          borrow_r <= slice_borrow_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            borrow_out  <= slice_borrow_s;
            overflow    <= ovf_s;
            zero        <= (next_diff_s == {WIDTH{1'b0}});
`ifdef SUB32_SERIAL_COMPARE_EN
            lt_unsigned <= slice_borrow_s;
            lt_signed   <= next_diff_s[WIDTH-1] ^ ovf_s;
            eq          <= (next_diff_s == {WIDTH{1'b0}});
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub32_serial.sv
// Randomized self-checking bench for sub32_serial against an arithmetic model.
module tb_sub32_serial;

  localparam int NS = 8;

  typedef struct packed {
    logic [31:0] diff;
    logic        bo;
    logic        ov;
    logic        z;
    logic        lts;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, borrow_in, out_valid, out_ready;
  logic [31:0] a, b, res_diff;
  logic        borrow_out, overflow, zero;
`ifdef SUB32_SERIAL_COMPARE_EN
  logic        lt_unsigned, lt_signed, eq;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;
  bit   m_busy   = 1'b0;
  int   m_age    = 0;
  res_t m_pend   = '0;
  res_t m_res    = '0;

  always #5 clk = ~clk;

  sub32_serial dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_diff   (res_diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
`ifdef SUB32_SERIAL_COMPARE_EN
    ,
    .lt_unsigned(lt_unsigned),
    .lt_signed  (lt_signed),
    .eq         (eq)
`endif
  );

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic bin);
    res_t   r;
    longint sd;
    r.diff = x - y - {31'd0, bin};
    r.bo   = ({1'b0, x} < ({1'b0, y} + {32'd0, bin}));
    sd     = longint'($signed(x)) - longint'($signed(y)) - longint'(bin);
    r.ov   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    r.z    = (r.diff == 32'd0);
    r.lts  = (sd < 64'sd0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: accept in idle, result after NS slices, release on out_ready.
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_res  = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_pend = model(a, b, borrow_in);
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else if (m_age < NS) begin
      m_age++;
      if (m_age == NS) m_res = m_pend;
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_busy && (m_age == NS));
      if (!m_busy || m_age == NS) begin
        chk("res_diff", res_diff, m_res.diff);
        chk("borrow_out", borrow_out, m_res.bo);
        chk("overflow", overflow, m_res.ov);
        chk("zero", zero, m_res.z);
`ifdef SUB32_SERIAL_COMPARE_EN
        chk("lt_unsigned", lt_unsigned, m_res.bo);
        chk("lt_signed", lt_signed, m_res.lts);
        chk("eq", eq, m_res.z);
`endif
      end
    end
  end

  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_bin,
                        input int hold, input bit lit, input logic [31:0] e_diff,
                        input logic e_bo, input logic e_ov, input logic e_z, input logic e_ls);
    bit got = 1'b0;
    int lat = 0;
    a = op_a; b = op_b; borrow_in = op_bin; in_valid = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) in_valid = 1'b0;
      else in_valid = ($urandom_range(0, 2) == 0);
      a = $urandom; b = $urandom; borrow_in = 1'($urandom_range(0, 1));
      if (out_valid) begin
        lat = cyc - 1;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: out_valid never rose within 20 cycles");
    end else begin
      chk("latency", lat, NS);
    end
    if (lit) begin
      chk("lit_diff", res_diff, e_diff);
      chk("lit_borrow", borrow_out, e_bo);
      chk("lit_ovf", overflow, e_ov);
      chk("lit_zero", zero, e_z);
`ifdef SUB32_SERIAL_COMPARE_EN
      chk("lit_ltu", lt_unsigned, e_bo);
      chk("lit_lts", lt_signed, e_ls);
      chk("lit_eq", eq, e_z);
`endif
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    res_t        mr;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", res_diff, 32'd0);
    chk("rst_flags", {borrow_out, overflow, zero}, 3'b000);
    reset  = 1'b0;
    chk_en = 1'b1;

    mr = model(32'h8000_0000, 32'h0000_0001, 1'b0);
    chk("model_ovf", {mr.diff, mr.bo, mr.ov}, {32'h7FFF_FFFF, 1'b0, 1'b1});
    mr = model(32'h1234_5678, 32'h1234_5678, 1'b1);
    chk("model_bin", {mr.diff, mr.bo, mr.z}, {32'hFFFF_FFFF, 1'b1, 1'b0});

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 5, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort an operation with reset while the slice counter is at 4.
    a = 32'hDEAD_BEEF; b = 32'h0123_4567; borrow_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_diff", res_diff, 32'd0);
    chk("abort_flags", {borrow_out, overflow, zero}, 3'b000);
    run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 0, 1'b1, 32'hFFFF_FFEF, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = ($urandom_range(0, 4) == 0) ? ra : pick();
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0,
             32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sub32_serial.md
Name: sub32_serial

Overview:
Multi-cycle 32-bit subtractor for the ALU datapath. It computes A - B - borrow_in one 4-bit slice per clock, LSB slice first, and ripples the borrow through a register between slices. It gives the ALU a small-area subtract and compare path next to the combinational adder chain, with a valid/ready handshake on both sides.

Parameters:
WIDTH, 32, operand width; must be a multiple of SLICE
SLICE, 4, bits processed per cycle
NUM_SLICES, WIDTH/SLICE (8), derived; cycles spent in RUN

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  incoming borrow
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
res_diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
borrow_out  output  1  1 iff unsigned a < b + borrow_in
overflow  output  1  signed overflow of the subtraction
zero  output  1  res_diff == 0

Behaviour:
- Reset: state IDLE, slice counter 0, borrow register 0, res_diff 0, borrow_out 0, overflow 0, zero 0, out_valid 0, in_ready 1.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch a, b and borrow_in into the borrow register, clear counter, go to RUN.
- State RUN:
  - Each cycle, slice k = counter computes a[k*4+3:k*4] + ~b_slice + ~borrow.
  - Slice difference is written into res_diff at slice k; borrow register <= ~carry_out.
  - Counter increments by 1.
  - On counter == NUM_SLICES-1, go to DONE. Final borrow goes to borrow_out.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, both taken from the last slice.
  - zero is computed from the full res_diff on the DONE transition.
- State DONE:
  - out_valid=1; all outputs held stable.
  - On out_ready, go to IDLE. out_valid drops the next cycle; result registers keep their values.
- Latency: operands accepted at edge 0; out_valid is high after edge NUM_SLICES (8). Throughput is one operation per NUM_SLICES+2 cycles, minimum.
- in_valid while RUN or DONE: ignored, no effect. Operand inputs are sampled only at acceptance.
- out_ready while not DONE: ignored.
- out_ready and in_valid asserted together in DONE: result is consumed; operands are not accepted that cycle because in_ready=0.
- Reset mid-RUN or in DONE: returns to the reset state on the next edge; the partial result is discarded.
- Wrap-around: results are modulo 2^WIDTH. borrow_out covers unsigned underflow; overflow covers signed.

Optional Feature:
SUB32_SERIAL_COMPARE_EN:
- Defined: adds outputs lt_unsigned (= borrow_out), lt_signed (= res_diff[WIDTH-1] XOR overflow) and eq (= zero). These are registered and valid with out_valid, and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH, SLICE, NUM_SLICES constants
  - the 2-bit state encoding (IDLE=0, RUN=1, DONE=2)
  - the counter width $clog2(NUM_SLICES)
- One sub-module, sub_slice4: combinational 4-bit generate/propagate lookahead subtract slice.
  - Inputs: a4, b4, borrow_in.
  - Outputs: diff4, borrow_out, carry_into_msb.
  - Instantiated once and time-multiplexed by the counter.

Test Plan:
- a=0x00000005, b=0x00000003, borrow_in=0 -> res_diff=0x00000002, borrow_out=0, overflow=0, zero=0; out_valid 8 cycles after acceptance.
- a=0x00000000, b=0x00000001, borrow_in=0 -> res_diff=0xFFFFFFFF, borrow_out=1, overflow=0; with the macro defined, lt_unsigned=1, lt_signed=1.
- a=0x80000000, b=0x00000001, borrow_in=0 -> res_diff=0x7FFFFFFF, overflow=1, borrow_out=0.
- a=b=0x12345678:
  - borrow_in=0 -> res_diff=0, zero=1, borrow_out=0.
  - Repeat with borrow_in=1 -> res_diff=0xFFFFFFFF, borrow_out=1, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, and pulse in_valid with new operands during RUN and DONE -> outputs stable, in_ready=0 throughout, the new operands are never latched.
- Assert reset for one cycle at counter=4 -> next cycle state IDLE, in_ready=1, out_valid=0, all result outputs 0. A following operation produces a correct result.
